// File: rtl/synth_pkg.sv
// Shared types and constants for the note_voice oscillator/envelope datapath.
// sine_value() builds the quarter-symmetric sine table at elaboration time.
package synth_pkg;

    localparam int                PHASE_W    = 24;
    localparam int                SAMPLE_W   = 16;
    localparam logic [15:0]       ENV_MAX    = 16'hFFFF;
    localparam logic signed [15:0] FULL_SCALE = 16'sd32767;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    localparam logic [1:0] WAVE_SAW    = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_SINE   = 2'd3;

    // Q30 Taylor series on the first quadrant; other quadrants by symmetry.
    function automatic logic signed [15:0] sine_value(input int idx);
        longint x;
        longint term;
        longint sum;
        longint mag;
        int     k;
        bit     neg;
        k   = (idx[6]) ? (64 - (idx & 63)) : (idx & 63);
        neg = idx[7];
        x    = (longint'(k) * 64'sd3373259426) / 64'sd128;
        term = x;
        sum  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        mag = (sum * 64'sd32767 + 64'sd536870912) >>> 30;
        if (mag > 64'sd32767) mag = 64'sd32767;
        if (mag < 64'sd0)     mag = 64'sd0;
        return 16'(neg ? -mag : mag);
    endfunction

endpackage

// File: rtl/sine_rom.sv
// Synchronous 256x16 signed sine ROM, peak +/-32767; exists only when
// SINE_LUT_EN is defined so the default build carries no unused module.
`ifdef SINE_LUT_EN
module sine_rom
    import synth_pkg::*;
(
    input  logic               clk,
    input  logic               en,
    input  logic [7:0]         addr,
    output logic signed [15:0] data
);

    logic signed [15:0] rom [256];

    for (genvar i = 0; i < 256; i++) begin : g_rom
        localparam logic signed [15:0] VALUE = sine_value(i);
        assign rom[i] = VALUE;
    end

    always_ff @(posedge clk) begin
        if (en) data <= rom[addr];
    end

endmodule
`endif

// File: rtl/note_voice.sv
// Single voice: phase accumulator, waveform shaper, A/S/R envelope, 2-stage output pipe.
// SINE_LUT_EN defined: wave_sel=3 plays a sine ROM; undefined: wave_sel=3 is silence.
module note_voice
    import synth_pkg::*;
#(
    parameter logic [15:0] ATTACK_STEP  = 16'd64,
    parameter logic [15:0] RELEASE_STEP = 16'd32
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                sample_tick,
    input  logic [23:0]         note_in,
    input  logic [1:0]          wave_sel,
    output logic signed [15:0]  sample_out,
    output logic                sample_valid,
    output logic                voice_active,
    output env_state_t          dbg_state,
    output logic [15:0]         dbg_env,
    output logic [23:0]         dbg_phase
);

    env_state_t         state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] held_q, held_d;
    logic [PHASE_W-1:0] eff_inc;
    logic [15:0]        env_q, env_d;
    logic [16:0]        env_up, env_dn;
    logic               gate;
    logic               active_q;

    assign gate    = (note_in != '0);
    assign eff_inc = gate ? note_in : held_q;
    assign env_up  = {1'b0, env_q} + {1'b0, ATTACK_STEP};
    assign env_dn  = {1'b0, env_q} - {1'b0, RELEASE_STEP};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            held_q   <= '0;
            env_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            held_q   <= held_d;
            env_q    <= env_d;
            active_q <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        phase_d = phase_q;
        held_d  = held_q;
        if (sample_tick) begin
            if (gate) held_d = note_in;
            // A note change while gated is legato: only the increment changes.
            phase_d = (state_q == IDLE) ? '0 : phase_q + eff_inc;
            case (state_q)
                IDLE: begin
                    if (gate) begin
                        state_d = ATTACK;
                        env_d   = ATTACK_STEP;
                    end
                end
                ATTACK: begin
                    if (!gate) begin
                        state_d = RELEASE;
                    end else if (env_up[16] || env_up[15:0] == ENV_MAX) begin
                        state_d = SUSTAIN;
                        env_d   = ENV_MAX;
                    end else begin
                        env_d = env_up[15:0];
                    end
                end
                SUSTAIN: begin
                    env_d = ENV_MAX;
                    if (!gate) state_d = RELEASE;
                end
                RELEASE: begin
                    if (gate) begin
                        state_d = ATTACK;
                    end else if (env_dn[16] || env_dn[15:0] == '0) begin
                        state_d = IDLE;
                        env_d   = '0;
                    end else begin
                        env_d = env_dn[15:0];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stage 1: shape the wave from the just-updated phase; wave_sel is sampled here.
    logic               tick_q;
    logic               wave_vld_q;
    logic signed [15:0] wave_c;
    logic signed [15:0] wave_q;
    logic signed [15:0] wave_s1;
    logic [15:0]        env_s1_q;

    always_comb begin
        wave_c = '0;
        case (wave_sel)
            WAVE_SAW:    wave_c = phase_q[23:8] ^ 16'h8000;
            WAVE_SQUARE: wave_c = phase_q[23] ? -FULL_SCALE : FULL_SCALE;
            WAVE_TRI:    wave_c = (phase_q[23] ? ~phase_q[22:7] : phase_q[22:7]) ^ 16'h8000;
            default:     wave_c = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_q     <= 1'b0;
            wave_vld_q <= 1'b0;
            wave_q     <= '0;
            env_s1_q   <= '0;
        end else begin
            tick_q     <= sample_tick;
            wave_vld_q <= tick_q;
            if (tick_q) begin
                wave_q   <= wave_c;
                env_s1_q <= env_q;
            end
        end
    end

`ifdef SINE_LUT_EN
    logic               sine_sel_q;
    logic signed [15:0] sine_q;

    sine_rom u_sine_rom (
        .clk  (Clk),
        .en   (tick_q),
        .addr (phase_q[23:16]),
        .data (sine_q)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)    sine_sel_q <= 1'b0;
        else if (tick_q) sine_sel_q <= (wave_sel == WAVE_SINE);
    end

    assign wave_s1 = sine_sel_q ? sine_q : wave_q;
`else
    assign wave_s1 = wave_q;
`endif

    // Stage 2: signed wave x unsigned env, arithmetic floor by 2^16.
    logic signed [32:0] prod;
    logic               prod_unused;

    assign prod        = $signed({{17{wave_s1[15]}}, wave_s1}) * $signed({17'b0, env_s1_q});
    assign prod_unused = ^{prod[32], prod[15:0]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= wave_vld_q;
            if (wave_vld_q) sample_out <= prod[31:16];
        end
    end

    assign voice_active = active_q;
    assign dbg_state    = state_q;
    assign dbg_env      = env_q;
    assign dbg_phase    = phase_q;

endmodule

// File: tb/tb_note_voice.sv
// Directed bench for note_voice: reference model feeds an expected-sample queue,
// a negedge monitor pops and checks each sample_valid pulse and its latency.
`timescale 1ns/1ps
module tb_note_voice;
    import synth_pkg::*;

    // clock / reset
    logic               Clk = 1'b0;
    logic               Reset_n = 1'b1;
    logic               sample_tick = 1'b0;
    logic [23:0]        note_in = '0;
    logic [1:0]         wave_sel = '0;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               voice_active;
    env_state_t         dbg_state;
    logic [15:0]        dbg_env;
    logic [23:0]        dbg_phase;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [15:0] exp_q[$];
    int          due_q[$];
    logic [15:0] last_exp = '0;

    int         m_phase = 0;
    int         m_env = 0;
    int         m_held = 0;
    env_state_t m_state = IDLE;

    note_voice dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .sample_tick  (sample_tick),
        .note_in      (note_in),
        .wave_sel     (wave_sel),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .voice_active (voice_active),
        .dbg_state    (dbg_state),
        .dbg_env      (dbg_env),
        .dbg_phase    (dbg_phase)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // reference model
    function automatic logic [15:0] sine_model(input int idx);
`ifdef SINE_LUT_EN
        if (idx == 64)  return 16'h7FFF;
        if (idx == 192) return 16'h8001;
`endif
        return 16'h0000;
    endfunction

    function automatic int wave_of(input int p, input logic [1:0] sel);
        logic [15:0] w;
        int t;
        case (sel)
            2'd0: w = 16'((p >> 8) ^ 32'h8000);
            2'd1: w = (p >= 32'h800000) ? 16'h8001 : 16'h7FFF;
            2'd2: begin
                t = (p >> 7) & 32'hFFFF;
                if (p >= 32'h800000) t = 32'hFFFF - t;
                w = 16'(t ^ 32'h8000);
            end
            default: w = sine_model(p >> 16);
        endcase
        return int'($signed(w));
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_env   = 0;
        m_held  = 0;
        m_state = IDLE;
        exp_q.delete();
        due_q.delete();
    endtask

    task automatic model_tick(input logic [23:0] note);
        int inc;
        int w;
        longint prod;
        logic [15:0] e;
        inc = (note != 0) ? int'(note) : m_held;
        if (note != 0) m_held = int'(note);
        if (m_state == IDLE) m_phase = 0;
        else m_phase = (m_phase + inc) % 32'h1000000;
        case (m_state)
            IDLE: if (note != 0) begin m_state = ATTACK; m_env = 64; end
            ATTACK: begin
                if (note == 0) m_state = RELEASE;
                else begin
                    m_env = m_env + 64;
                    if (m_env >= 65535) begin m_env = 65535; m_state = SUSTAIN; end
                end
            end
            SUSTAIN: if (note == 0) m_state = RELEASE;
            RELEASE: begin
                if (note != 0) m_state = ATTACK;
                else begin
                    m_env = m_env - 32;
                    if (m_env <= 0) begin m_env = 0; m_state = IDLE; end
                end
            end
            default: m_state = IDLE;
        endcase
        w = wave_of(m_phase, wave_sel);
        prod = longint'(w) * longint'(m_env);
        e = 16'(prod >>> 16);
        exp_q.push_back(e);
        due_q.push_back(cyc + 3);
        last_exp = e;
    endtask

    // driver tasks
    task automatic do_tick(input logic [23:0] note);
        @(negedge Clk);
        sample_tick = 1'b1;
        note_in = note;
        model_tick(note);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            sample_tick = 1'b0;
            note_in = '0;
        end
    endtask

    task automatic set_wave(input logic [1:0] sel);
        idle(3);
        wave_sel = sel;
    endtask

    task automatic chk_core(input string tag);
        chk({tag, "_state"}, dbg_state, m_state);
        chk({tag, "_env"}, dbg_env, m_env);
        chk({tag, "_phase"}, dbg_phase, m_phase);
        chk({tag, "_active"}, voice_active, m_state != IDLE);
    endtask

    // scoreboard monitor
    always @(negedge Clk) begin
        logic [15:0] e;
        int d;
        if (Reset_n && sample_valid) begin
            chk("valid_has_expect", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                d = due_q.pop_front();
                chk("sample", $unsigned(sample_out), e);
                chk("latency", cyc, d);
            end
        end
    end

    initial begin
        #1 Reset_n = 1'b0;
        #11;
        chk("rst_sample_out", $unsigned(sample_out), 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_active", voice_active, 0);
        chk("rst_state", dbg_state, IDLE);
        chk("rst_phase", dbg_phase, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // gate off: silence, no voice
        for (int i = 0; i < 10; i++) begin
            do_tick(24'h0);
            idle($urandom_range(0, 2));
        end
        idle(3);
        chk("gateoff_active", voice_active, 0);
        chk("gateoff_state", dbg_state, IDLE);
        chk("gateoff_out", $unsigned(sample_out), 0);

        // attack to sustain with square
        set_wave(WAVE_SQUARE);
        repeat (1023) do_tick(24'h024e8f);
        idle(1);
        chk("attack_state", dbg_state, ATTACK);
        chk("attack_env", dbg_env, 16'hFFC0);
        chk("attack_active", voice_active, 1);
        do_tick(24'h024e8f);
        idle(1);
        chk("sustain_state", dbg_state, SUSTAIN);
        chk("sustain_env", dbg_env, 16'hFFFF);
        repeat (8) do_tick(24'h024e8f);
        idle(3);
        chk("sustain_hold", $unsigned(sample_out), last_exp);
        chk("sustain_mag", (sample_out == 16'sd32766) || (sample_out == -16'sd32767), 1);
        chk_core("sustain");

        // release halfway, then re-attack from the current level
        repeat (1025) do_tick(24'h0);
        idle(1);
        chk("rel_state", dbg_state, RELEASE);
        chk("rel_env", dbg_env, 16'h7FFF);
        chk_core("rel");
        do_tick(24'h015f27);
        idle(1);
        chk("reatk_state", dbg_state, ATTACK);
        chk("reatk_env", dbg_env, 16'h7FFF);
        repeat (511) do_tick(24'h015f27);
        idle(1);
        chk("reatk511_state", dbg_state, ATTACK);
        chk("reatk511_env", dbg_env, 16'hFFBF);
        do_tick(24'h015f27);
        idle(1);
        chk("reatk512_state", dbg_state, SUSTAIN);
        chk("reatk512_env", dbg_env, 16'hFFFF);

        // full release to idle
        repeat (2048) do_tick(24'h0);
        idle(1);
        chk("tail_state", dbg_state, RELEASE);
        chk("tail_env", dbg_env, 16'h001F);
        chk_core("tail");
        do_tick(24'h0);
        idle(1);
        chk("end_state", dbg_state, IDLE);
        chk("end_env", dbg_env, 0);
        chk("end_active", voice_active, 0);
        do_tick(24'h0);
        idle(1);
        chk("end_phase", dbg_phase, 0);

        // saw at half-cycle increment: phase wraps cleanly
        set_wave(WAVE_SAW);
        do_tick(24'h800000);
        idle(1);
        chk("saw_phase0", dbg_phase, 24'h000000);
        do_tick(24'h800000);
        idle(1);
        chk("saw_phase1", dbg_phase, 24'h800000);
        do_tick(24'h800000);
        idle(1);
        chk("saw_phase2", dbg_phase, 24'h000000);
        repeat (6) do_tick(24'h800000);
        idle(3);
        chk("saw_hold", $unsigned(sample_out), last_exp);

        // triangle with random legato notes and short gate gaps
        set_wave(WAVE_TRI);
        repeat (60) begin
            if ($urandom_range(0, 4) == 0) do_tick(24'h0);
            else do_tick(24'($urandom_range(1, 32'hFFFFFF)));
        end
        idle(3);
        chk_core("tri");

        // sine peaks from a clean start
        @(negedge Clk);
        Reset_n = 1'b0;
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
        set_wave(WAVE_SINE);
        repeat (1030) do_tick(24'h400000);
        idle(3);
        chk("sine_state", dbg_state, SUSTAIN);
        chk("sine_phase", dbg_phase, 24'h400000);
`ifdef SINE_LUT_EN
        chk("sine_peak", $unsigned(sample_out), 16'd32766);
`else
        chk("sine_peak", $unsigned(sample_out), 16'd0);
`endif
        do_tick(24'h400000);
        do_tick(24'h400000);
        idle(3);
`ifdef SINE_LUT_EN
        chk("sine_trough", $unsigned(sample_out), 16'h8001);
`else
        chk("sine_trough", $unsigned(sample_out), 16'd0);
`endif

        // asynchronous reset in the middle of a sustained square note
        set_wave(WAVE_SQUARE);
        repeat (4) do_tick(24'h400000);
        idle(3);
        chk("prerst_hold", $unsigned(sample_out), last_exp);
        chk("prerst_active", voice_active, 1);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_sample_out", $unsigned(sample_out), 0);
        chk("arst_valid", sample_valid, 0);
        chk("arst_active", voice_active, 0);
        chk("arst_state", dbg_state, IDLE);
        chk("arst_env", dbg_env, 0);
        chk("arst_phase", dbg_phase, 0);
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;

        repeat (3) do_tick(24'h0);
        idle(5);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
